// File: rtl/eth_frame_log_merger.sv
// eth_frame_log_merger: packet-atomic 2:1 round-robin merger of two log
// streams into one AXI4-Stream, with source tag on tid and a 2-entry
// registered output buffer.
//
// Ports:
//   clk, rst_n (async, active-low), srst (sync soft reset, active-high)
//   s_axis_log_a_* / s_axis_log_b_* : input log streams (tdata, tlast, tvalid, tready)
//   m_axis_log_*                    : merged stream (tdata, tid, tlast, tvalid, tready)
//   pkt_count_a / pkt_count_b       : wrapping counts of accepted records per source
module eth_frame_log_merger #(
  parameter int unsigned C_AXIS_LOG_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        srst,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_a_tdata,
  input  logic                        s_axis_log_a_tlast,
  input  logic                        s_axis_log_a_tvalid,
  output logic                        s_axis_log_a_tready,
  input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_b_tdata,
  input  logic                        s_axis_log_b_tlast,
  input  logic                        s_axis_log_b_tvalid,
  output logic                        s_axis_log_b_tready,
  output logic [C_AXIS_LOG_WIDTH-1:0] m_axis_log_tdata,
  output logic                        m_axis_log_tid,
  output logic                        m_axis_log_tlast,
  output logic                        m_axis_log_tvalid,
  input  logic                        m_axis_log_tready,
  output logic [31:0]                 pkt_count_a,
  output logic [31:0]                 pkt_count_b
);

  localparam int unsigned DW = C_AXIS_LOG_WIDTH;
  localparam int unsigned CW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS_A = 2'd1,
    PASS_B = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_grant;      // 0 = A, 1 = B
  logic            last_grant_nxt;
  logic [1:0]      count;           // output buffer occupancy (0..2)
  logic [1:0]      count_nxt;

  logic            acc_a;
  logic            acc_b;
  logic            rec_done_a;
  logic            rec_done_b;
  logic            push;
  logic            pop;
  logic [DW-1:0]   push_data;
  logic            push_last;
  logic            push_tid;
  logic            ready_a_nxt;
  logic            ready_b_nxt;

  // Second buffer entry; the head entry is the m_axis_log_* register set.
  logic [DW-1:0]   tail_data;
  logic            tail_last;
  logic            tail_tid;

  // Next-state, handshake and occupancy decode.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;

    acc_a      = s_axis_log_a_tvalid & s_axis_log_a_tready;
    acc_b      = s_axis_log_b_tvalid & s_axis_log_b_tready;
    rec_done_a = acc_a & s_axis_log_a_tlast;
    rec_done_b = acc_b & s_axis_log_b_tlast;
    push       = acc_a | acc_b;
    pop        = m_axis_log_tvalid & m_axis_log_tready;
    push_data  = acc_b ? s_axis_log_b_tdata : s_axis_log_a_tdata;
    push_last  = acc_b ? s_axis_log_b_tlast : s_axis_log_a_tlast;
    push_tid   = acc_b;

    unique case (state)
      IDLE: begin
        // On a tie, A wins only if B had the previous grant.
        if (s_axis_log_a_tvalid && (!s_axis_log_b_tvalid || last_grant)) begin
          state_nxt      = PASS_A;
          last_grant_nxt = 1'b0;
        end else if (s_axis_log_b_tvalid) begin
          state_nxt      = PASS_B;
          last_grant_nxt = 1'b1;
        end
      end
      PASS_A:  if (rec_done_a) state_nxt = IDLE;
      PASS_B:  if (rec_done_b) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    count_nxt = count + 2'(push) - 2'(pop);

    // tready is registered from next-cycle state and occupancy, so it never
    // depends combinationally on m_axis_log_tready.
    ready_a_nxt = (state_nxt == PASS_A) && (count_nxt < 2'd2);
    ready_b_nxt = (state_nxt == PASS_B) && (count_nxt < 2'd2);
  end

  // State, buffer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      last_grant          <= 1'b1;
      count               <= 2'd0;
      s_axis_log_a_tready <= 1'b0;
      s_axis_log_b_tready <= 1'b0;
      m_axis_log_tvalid   <= 1'b0;
      m_axis_log_tdata    <= '0;
      m_axis_log_tlast    <= 1'b0;
      m_axis_log_tid      <= 1'b0;
      tail_data           <= '0;
      tail_last           <= 1'b0;
      tail_tid            <= 1'b0;
      pkt_count_a         <= '0;
      pkt_count_b         <= '0;
    end else if (srst) begin
      state               <= IDLE;
      last_grant          <= 1'b1;
      count               <= 2'd0;
      s_axis_log_a_tready <= 1'b0;
      s_axis_log_b_tready <= 1'b0;
      m_axis_log_tvalid   <= 1'b0;
      m_axis_log_tdata    <= '0;
      m_axis_log_tlast    <= 1'b0;
      m_axis_log_tid      <= 1'b0;
      tail_data           <= '0;
      tail_last           <= 1'b0;
      tail_tid            <= 1'b0;
      pkt_count_a         <= '0;
      pkt_count_b         <= '0;
    end else begin
      state               <= state_nxt;
      last_grant          <= last_grant_nxt;
      count               <= count_nxt;
      s_axis_log_a_tready <= ready_a_nxt;
      s_axis_log_b_tready <= ready_b_nxt;
      m_axis_log_tvalid   <= (count_nxt != 2'd0);

      // Head: refill from tail when a full buffer pops, or take the new
      // beat when the buffer is (or becomes) empty at the head.
      if (pop && count == 2'd2) begin
        m_axis_log_tdata <= tail_data;
        m_axis_log_tlast <= tail_last;
        m_axis_log_tid   <= tail_tid;
      end else if (push && (count == 2'd0 || (pop && count == 2'd1))) begin
        m_axis_log_tdata <= push_data;
        m_axis_log_tlast <= push_last;
        m_axis_log_tid   <= push_tid;
      end

      if (push && !pop && count == 2'd1) begin
        tail_data <= push_data;
        tail_last <= push_last;
        tail_tid  <= push_tid;
      end

      if (rec_done_a) pkt_count_a <= pkt_count_a + CW'(1);
      if (rec_done_b) pkt_count_b <= pkt_count_b + CW'(1);
    end
  end

endmodule

// File: tb/tb_eth_frame_log_merger.sv
// Testbench for eth_frame_log_merger: queue-driven sources, a record-level
// scoreboard (per-source ordering, no interleaving, tid), directed timing
// checks, an arbitration vector table and randomized traffic.
module tb_eth_frame_log_merger;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         srst;
  logic [W-1:0] s_a_tdata;
  logic         s_a_tlast;
  logic         s_a_tvalid;
  logic         s_a_tready;
  logic [W-1:0] s_b_tdata;
  logic         s_b_tlast;
  logic         s_b_tvalid;
  logic         s_b_tready;
  logic [W-1:0] m_tdata;
  logic         m_tid;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [31:0]  pkt_a;
  logic [31:0]  pkt_b;

  eth_frame_log_merger #(.C_AXIS_LOG_WIDTH(W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .srst                (srst),
    .s_axis_log_a_tdata  (s_a_tdata),
    .s_axis_log_a_tlast  (s_a_tlast),
    .s_axis_log_a_tvalid (s_a_tvalid),
    .s_axis_log_a_tready (s_a_tready),
    .s_axis_log_b_tdata  (s_b_tdata),
    .s_axis_log_b_tlast  (s_b_tlast),
    .s_axis_log_b_tvalid (s_b_tvalid),
    .s_axis_log_b_tready (s_b_tready),
    .m_axis_log_tdata    (m_tdata),
    .m_axis_log_tid      (m_tid),
    .m_axis_log_tlast    (m_tlast),
    .m_axis_log_tvalid   (m_tvalid),
    .m_axis_log_tready   (m_tready),
    .pkt_count_a         (pkt_a),
    .pkt_count_b         (pkt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
    logic         last;
    logic         tid;
  } obeat_t;

  typedef struct {
    bit   a;
    bit   b;
    logic tid0;
    logic tid1;
    int   n;
  } arb_vec_t;

  beat_t    a_q[$];
  beat_t    b_q[$];
  beat_t    exp_a[$];
  beat_t    exp_b[$];
  obeat_t   out_log[$];
  arb_vec_t tbl[6];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_a_tot = 0;
  int          a_first_cyc = -1;
  bit          acc_a_f = 1'b0;
  bit          acc_b_f = 1'b0;
  bit          gap_en = 1'b0;
  bit          rand_rdy = 1'b0;
  bit          out_mid = 1'b0;
  logic        out_prev_tid = 1'b0;
  logic [31:0] mdl_a = '0;
  logic [31:0] mdl_b = '0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic send_beat(input bit src, input logic [W-1:0] data, input logic last);
    beat_t bt;
    bt.data = data;
    bt.last = last;
    if (src) begin
      b_q.push_back(bt);
      exp_b.push_back(bt);
      if (last) mdl_b = mdl_b + 32'd1;
    end else begin
      a_q.push_back(bt);
      exp_a.push_back(bt);
      if (last) mdl_a = mdl_a + 32'd1;
    end
  endtask

  task automatic send(input bit src, input int n, input logic [W-1:0] base);
    for (int j = 0; j < n; j++) send_beat(src, base + W'(j), j == n - 1);
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (out_log.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, 72'(out_log.size() >= n), 72'd1);
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    mdl_a = '0;
    mdl_b = '0;
    out_mid = 1'b0;
  endtask

  // Sources: advance on the handshake seen at the previous negedge; tvalid
  // holds until accepted; optional random gaps between beats.
  always @(posedge clk) begin
    beat_t tmp;
    cyc++;
    #1;
    if (acc_a_f && a_q.size() > 0) tmp = a_q.pop_front();
    if (acc_b_f && b_q.size() > 0) tmp = b_q.pop_front();
    if (a_q.size() == 0) s_a_tvalid = 1'b0;
    else if (!s_a_tvalid || acc_a_f) s_a_tvalid = !gap_en || ($urandom_range(0, 2) != 0);
    if (a_q.size() > 0) begin
      s_a_tdata = a_q[0].data;
      s_a_tlast = a_q[0].last;
    end
    if (b_q.size() == 0) s_b_tvalid = 1'b0;
    else if (!s_b_tvalid || acc_b_f) s_b_tvalid = !gap_en || ($urandom_range(0, 2) != 0);
    if (b_q.size() > 0) begin
      s_b_tdata = b_q[0].data;
      s_b_tlast = b_q[0].last;
    end
    if (rand_rdy) m_tready = ($urandom_range(0, 3) != 0);
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    obeat_t o;
    beat_t  e;
    bit     have;
    acc_a_f = s_a_tvalid && s_a_tready;
    acc_b_f = s_b_tvalid && s_b_tready;
    if (acc_a_f) acc_a_tot++;
    if (s_a_tvalid && a_first_cyc < 0) a_first_cyc = cyc;
    if (m_tvalid && m_tready) begin
      o.cyc  = cyc;
      o.data = m_tdata;
      o.last = m_tlast;
      o.tid  = m_tid;
      out_log.push_back(o);
      if (out_mid) chk("no_interleave_tid", 72'(m_tid), 72'(out_prev_tid));
      have = 1'b0;
      if (m_tid == 1'b0 && exp_a.size() > 0) begin
        e = exp_a.pop_front();
        have = 1'b1;
      end else if (m_tid == 1'b1 && exp_b.size() > 0) begin
        e = exp_b.pop_front();
        have = 1'b1;
      end
      if (have) begin
        chk("out_beat{last,data}", {7'd0, m_tlast, m_tdata}, {7'd0, e.last, e.data});
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got tid %0d data %0h, expected no beat", m_tid, m_tdata);
      end
      out_mid = !m_tlast;
      out_prev_tid = m_tid;
    end
  end

  int idx;
  int vh;
  int a0;

  initial begin
    rst_n = 1'b0;
    srst = 1'b0;
    s_a_tdata = '0;
    s_a_tlast = 1'b0;
    s_a_tvalid = 1'b0;
    s_b_tdata = '0;
    s_b_tlast = 1'b0;
    s_b_tvalid = 1'b0;
    m_tready = 1'b1;

    // Arbitration vectors, starting right after a soft reset (B last granted).
    tbl[0] = '{a: 1'b1, b: 1'b1, tid0: 1'b0, tid1: 1'b1, n: 2};
    tbl[1] = '{a: 1'b1, b: 1'b0, tid0: 1'b0, tid1: 1'b0, n: 1};
    tbl[2] = '{a: 1'b1, b: 1'b1, tid0: 1'b1, tid1: 1'b0, n: 2};
    tbl[3] = '{a: 1'b0, b: 1'b1, tid0: 1'b1, tid1: 1'b1, n: 1};
    tbl[4] = '{a: 1'b1, b: 1'b1, tid0: 1'b0, tid1: 1'b1, n: 2};
    tbl[5] = '{a: 1'b1, b: 1'b1, tid0: 1'b0, tid1: 1'b1, n: 2};

    // Reset and idle.
    tick(3);
    chk("rst_ctrl", 72'({m_tvalid, m_tlast, m_tid, s_a_tready, s_b_tready}), 72'd0);
    chk("rst_tdata", 72'(m_tdata), 72'd0);
    chk("rst_counts", 72'({pkt_a, pkt_b}), 72'd0);
    rst_n = 1'b1;
    vh = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (m_tvalid) vh++;
    end
    chk("idle_tvalid_cycles", 72'(vh), 72'd0);
    chk("idle_ctrl", 72'({m_tvalid, m_tlast, m_tid, s_a_tready, s_b_tready}), 72'd0);

    // Single 3-beat A record.
    idx = out_log.size();
    a_first_cyc = -1;
    send_beat(1'b0, 64'h11, 1'b0);
    send_beat(1'b0, 64'h22, 1'b0);
    send_beat(1'b0, 64'h33, 1'b1);
    wait_out(idx + 3, 20, "single_wait");
    chk("single_latency", 72'(out_log[idx].cyc - a_first_cyc), 72'd2);
    chk("single_consec", 72'({out_log[idx+1].cyc - out_log[idx].cyc, out_log[idx+2].cyc - out_log[idx+1].cyc}), {8'd0, 32'd1, 32'd1});
    chk("single_tlast", 72'({out_log[idx].last, out_log[idx+1].last, out_log[idx+2].last}), 72'b001);
    chk("single_tid", 72'({out_log[idx].tid, out_log[idx+1].tid, out_log[idx+2].tid}), 72'b000);
    tick(2);
    chk("single_pkt_a", 72'(pkt_a), 72'd1);

    // Both sources continuously requesting from reset.
    pulse_rst();
    idx = out_log.size();
    send(1'b0, 2, 64'hA000);
    send(1'b0, 2, 64'hA100);
    send(1'b1, 2, 64'hB000);
    send(1'b1, 2, 64'hB100);
    wait_out(idx + 8, 60, "tie_wait");
    chk("tie_order", 72'({out_log[idx].tid, out_log[idx+2].tid, out_log[idx+4].tid, out_log[idx+6].tid}), 72'b0101);
    tick(2);
    chk("tie_counts", 72'({pkt_a, pkt_b}), {8'd0, 32'd2, 32'd2});

    // Backpressure on an 8-beat A record.
    m_tready = 1'b0;
    a0 = acc_a_tot;
    idx = out_log.size();
    send(1'b0, 8, 64'hC000);
    tick(10);
    chk("bp_accepted", 72'(acc_a_tot - a0), 72'd2);
    chk("bp_a_tready", 72'(s_a_tready), 72'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_hold", {5'd0, m_tvalid, m_tlast, m_tid, m_tdata}, {5'd0, 1'b1, 1'b0, 1'b0, 64'hC000});
    end
    m_tready = 1'b1;
    wait_out(idx + 8, 40, "bp_wait");
    tick(2);
    chk("bp_out_count", 72'(out_log.size() - idx), 72'd8);

    // Counter wrap on B.
    force dut.pkt_count_b = 32'hFFFF_FFFF;
    tick(1);
    release dut.pkt_count_b;
    mdl_b = 32'hFFFF_FFFF;
    idx = out_log.size();
    send(1'b1, 1, 64'hD000);
    wait_out(idx + 1, 20, "wrap_wait");
    tick(2);
    chk("wrap_pkt_b", 72'(pkt_b), 72'(mdl_b));
    chk("wrap_pkt_b_zero", 72'(pkt_b), 72'd0);

    // Soft reset with the buffer full.
    m_tready = 1'b0;
    a0 = acc_a_tot;
    send(1'b0, 4, 64'hE000);
    tick(8);
    chk("srst_pre_accepted", 72'(acc_a_tot - a0), 72'd2);
    chk("srst_pre_valid", 72'(m_tvalid), 72'd1);
    srst = 1'b1;
    a_q.delete();
    exp_a.delete();
    tick(1);
    srst = 1'b0;
    mdl_a = '0;
    mdl_b = '0;
    out_mid = 1'b0;
    chk("srst_tvalid", 72'(m_tvalid), 72'd0);
    chk("srst_counts", 72'({pkt_a, pkt_b}), 72'd0);
    chk("srst_treadys", 72'({s_a_tready, s_b_tready}), 72'd0);
    m_tready = 1'b1;
    tick(2);

    // Arbitration table (first entry is the post-srst tie).
    for (int i = 0; i < 6; i++) begin
      idx = out_log.size();
      if (tbl[i].a) send(1'b0, 1, W'(64'hF000 + 16 * i));
      if (tbl[i].b) send(1'b1, 1, W'(64'hF800 + 16 * i));
      wait_out(idx + tbl[i].n, 30, "tbl_wait");
      chk($sformatf("tbl%0d_tid0", i), 72'(out_log[idx].tid), 72'(tbl[i].tid0));
      if (tbl[i].n == 2) chk($sformatf("tbl%0d_tid1", i), 72'(out_log[idx+1].tid), 72'(tbl[i].tid1));
      tick(2);
    end
    chk("tbl_counts", 72'({pkt_a, pkt_b}), 72'({mdl_a, mdl_b}));

    // Randomized traffic with source gaps and consumer backpressure.
    gap_en = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), {$urandom, $urandom});
      tick(int'($urandom_range(0, 4)));
    end
    vh = 0;
    while ((exp_a.size() + exp_b.size()) > 0 && vh < 4000) begin
      tick(1);
      vh++;
    end
    chk("rand_drained", 72'(exp_a.size() + exp_b.size()), 72'd0);
    rand_rdy = 1'b0;
    gap_en = 1'b0;
    m_tready = 1'b1;
    tick(3);
    chk("rand_counts", 72'({pkt_a, pkt_b}), 72'({mdl_a, mdl_b}));
    chk("rand_idle", 72'(m_tvalid), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_frame_log_merger.md
# eth_frame_log_merger

Packet-atomic 2:1 arbiter that merges the two per-interface log streams of `eth_frame_detector` (`m_axis_log_a_*`, `m_axis_log_b_*`) into one AXI4-Stream for a single DMA/FIFO consumer. Each tlast-delimited log record passes through uninterleaved, tagged with its source on `tid`. A 2-entry output buffer provides registered outputs at full throughput. Per-source record counters are exposed for the register block.

## Interface

Parameters:

- `C_AXIS_LOG_WIDTH`, 64, log beat width; must match the detector's log width.

Ports:

- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `srst`  in  1  synchronous soft reset, active-high.
- `s_axis_log_a_tdata`  in  C_AXIS_LOG_WIDTH  log beat from interface A.
- `s_axis_log_a_tlast`  in  1  last beat of an A record.
- `s_axis_log_a_tvalid`  in  1  A beat valid.
- `s_axis_log_a_tready`  out  1  A beat accepted.
- `s_axis_log_b_*`  in/out  same widths as `s_axis_log_a_*`  identical port set for interface B.
- `m_axis_log_tdata`  out  C_AXIS_LOG_WIDTH  merged log beat.
- `m_axis_log_tid`  out  1  record source: 0 = A, 1 = B.
- `m_axis_log_tlast`  out  1  last beat of a record.
- `m_axis_log_tvalid`  out  1  merged beat valid.
- `m_axis_log_tready`  in  1  consumer ready.
- `pkt_count_a`  out  32  number of A records accepted.
- `pkt_count_b`  out  32  number of B records accepted.

## Operation

- FSM states:
  - IDLE: no grant.
  - PASS_A: A is granted.
  - PASS_B: B is granted.
- IDLE:
  - If exactly one `s_*_tvalid` is high, grant that source.
  - If both are high, grant the source other than `last_grant` (round-robin).
  - If neither is high, stay in IDLE.
  - On a grant, move to PASS_x on the next edge and set `last_grant` to x.
- PASS_x:
  - `s_axis_log_x_tready = (count < 2)`, where `count` is the buffer occupancy register (0..2).
  - The non-granted input's tready is 0.
  - Accepted beat = tvalid & tready on the granted input.
  - An accepted beat with tlast moves the FSM to IDLE and increments `pkt_count_x`.
- Inputs are never readied in IDLE. Every record therefore costs one arbitration bubble cycle.
- Output buffer:
  - 2-entry FIFO holding {tdata, tlast, tid}.
  - Push = accepted beat. Pop = `m_axis_log_tvalid & m_axis_log_tready`.
  - A simultaneous push and pop leaves `count` unchanged.
  - `m_axis_log_*` are driven from the head entry register; `m_axis_log_tvalid = (count != 0)`.
- Counters wrap from 0xFFFFFFFF to 0.
- `srst` (synchronous) clears FSM to IDLE, `last_grant` to B, `count` to 0 (buffer flushed) and both counters to 0. `srst` has priority over any same-cycle push, pop or count. Upstream logging must be disabled while `srst` is high; stream framing across `srst` is not preserved.
- `rst_n` low forces the same state asynchronously.

## Timing

- Reset values:
  - `s_*_tready`, `m_axis_log_tvalid`, `m_axis_log_tlast`, `m_axis_log_tid`: 0.
  - `m_axis_log_tdata`: 0.
  - `pkt_count_a`, `pkt_count_b`: 0.
  - FSM: IDLE. `last_grant`: B, so A wins the first tie.
- Latency:
  - First tvalid in IDLE at cycle t → tready at t+1 → beat accepted at t+1 → `m_axis_log_tvalid` at t+2.
  - Within a record, input-to-output latency is 1 cycle.
- Throughput:
  - With `m_axis_log_tready` held high, one beat per cycle within a record.
  - A record of N beats occupies N+1 cycles including the IDLE bubble.
- Backpressure:
  - `m_axis_log_tready` low stalls pops. Input tready falls once `count` = 2.
  - All tready outputs depend only on registers; there is no combinational path from `m_axis_log_tready` to `s_*_tready`.
- `m_axis_log_tdata`, `tlast` and `tid` are held stable while tvalid is high and tready is low.
- `pkt_count_x` updates on the edge after the accepted tlast beat.

## Test plan

- Reset and idle:
  - Stimulus: hold `rst_n` low, then release it with no input activity.
  - Required: all outputs read 0, and `m_axis_log_tvalid` stays 0 for 100 cycles.
- Single record:
  - Stimulus: A sends 3 beats 0x11, 0x22, 0x33 (tlast on 0x33) with `m_axis_log_tready` = 1.
  - Required: 3 output beats in consecutive cycles, first output 2 cycles after A's first tvalid; `tid` = 0; tlast on the 3rd beat only; `pkt_count_a` = 1.
- Simultaneous requests:
  - Stimulus: A and B both present 2-beat records continuously from reset.
  - Required: output records alternate A, B, A, B with no interleaving within a record; after 4 records, `pkt_count_a` = `pkt_count_b` = 2.
- Backpressure:
  - Stimulus: `m_axis_log_tready` = 0 during an 8-beat A record.
  - Required: exactly 2 beats are accepted and `s_axis_log_a_tready` drops. After tready is released, all 8 beats emerge in order, with the output stable throughout the stall.
- Counter wrap:
  - Stimulus: force `pkt_count_b` to 0xFFFFFFFF, then send one B record.
  - Required: `pkt_count_b` = 0.
- Soft reset:
  - Stimulus: assert `srst` for 1 cycle with 2 beats buffered and `count` = 2.
  - Required: next cycle `m_axis_log_tvalid` = 0, both counters = 0, FSM in IDLE; the next tie is won by A.
